// File: rtl/osc_seq_fsm.sv
// osc_seq_fsm: parametrised oscillating sequencer.
// Steps a registered position index through NUM_STATES positions while A is
// high, either wrapping (mode=0) or bouncing between the ends (mode=1).
// Optional feature macro: OSC_SEQ_DWELL_EN -- when defined, each position is
// held for DWELL enabled cycles; when undefined, every enabled edge advances.
module osc_seq_fsm #(
    parameter int unsigned NUM_STATES = 4,
    parameter int unsigned STATE_W    = 2,
    parameter int unsigned DWELL      = 1,
    parameter int unsigned DWELL_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               A,
    input  logic               mode,
    output logic [STATE_W-1:0] state,
    output logic               dir,
    output logic               end_pulse
);

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_PING = 1'b1
    } mode_e;

    localparam logic [STATE_W-1:0] LAST = STATE_W'(NUM_STATES - 1);

    // Reject parameter sets that the sequencer cannot honour.
    if (NUM_STATES < 2 || NUM_STATES > 2**STATE_W ||
        DWELL < 1 || DWELL > 2**DWELL_W - 1) begin : g_param_check
        $error("osc_seq_fsm: illegal parameter combination");
    end

    logic [STATE_W-1:0] state_q, state_d;
    dir_e               dir_q, dir_d;
    logic               pulse_q, pulse_d;
    logic               adv;

`ifdef OSC_SEQ_DWELL_EN
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] dwell_q, dwell_d;

    assign adv = A && (dwell_q == DWELL_LAST);

    // Dwell counter: counts enabled cycles, clears on advance, freezes when A is low.
    always_comb begin
        dwell_d = dwell_q;
        if (adv) begin
            dwell_d = '0;
        end else if (A) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    // Dwell counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end
`else
    assign adv = A;
`endif

    // Next position, direction and endpoint pulse; everything holds unless adv.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_d = state_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;
        if (adv) begin
            if (state_q > LAST) begin
                // Unreachable from reset; recover to a known position.
                state_d = '0;
                dir_d   = DIR_UP;
            end else if (mode_e'(mode) == MODE_WRAP) begin
                dir_d = DIR_UP;
                if (state_q == LAST) begin
                    state_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    state_d = state_q + 1'b1;
                end
            end else if (dir_q == DIR_UP) begin
                if (state_q == LAST) begin
                    state_d = LAST - 1'b1;
                    dir_d   = DIR_DOWN;
                    pulse_d = 1'b1;
                end else begin
                    state_d = state_q + 1'b1;
                end
            end else begin
                if (state_q == '0) begin
                    state_d = STATE_W'(1);
                    dir_d   = DIR_UP;
                    pulse_d = 1'b1;
                end else begin
                    state_d = state_q - 1'b1;
                end
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            dir_q   <= DIR_UP;
            pulse_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
        end
    end

    assign state     = state_q;
    assign dir       = dir_q;
    assign end_pulse = pulse_q;

endmodule

// File: tb/tb_osc_seq_fsm.sv
// tb_osc_seq_fsm: directed and randomised checks of osc_seq_fsm against a
// behavioural model of the sequencing rules. Honours OSC_SEQ_DWELL_EN.
module tb_osc_seq_fsm;

    localparam int N = 4;
`ifdef OSC_SEQ_DWELL_EN
    localparam int D = 3;
`else
    localparam int D = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       A = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] state;
    logic       dir;
    logic       end_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model of the sequencer.
    int m_state = 0;
    int m_dir   = 1;
    int m_pulse = 0;
    int m_cnt   = 0;

    osc_seq_fsm #(
        .NUM_STATES (N),
        .STATE_W    (2),
        .DWELL      (3),
        .DWELL_W    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .mode      (mode),
        .state     (state),
        .dir       (dir),
        .end_pulse (end_pulse)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_state = 0;
        m_dir   = 1;
        m_pulse = 0;
        m_cnt   = 0;
    endfunction

    // One rising edge of the model: dwell first, then a move along the line
    // of positions, bouncing off either end in ping-pong mode.
    function automatic void model_edge(input logic a_v, input logic mode_v);
        int nxt;
        m_pulse = 0;
        if (!a_v) return;
        if (m_cnt != D - 1) begin
            m_cnt = m_cnt + 1;
            return;
        end
        m_cnt = 0;
        if (!mode_v) begin
            m_dir = 1;
            if (m_state == N - 1) begin
                m_state = 0;
                m_pulse = 1;
            end else begin
                m_state = m_state + 1;
            end
        end else begin
            nxt = m_state + (m_dir != 0 ? 1 : -1);
            if (nxt < 0 || nxt > N - 1) begin
                m_dir   = (m_dir != 0) ? 0 : 1;
                m_pulse = 1;
                nxt     = m_state + (m_dir != 0 ? 1 : -1);
            end
            m_state = nxt;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".state"}, 32'(state), 32'(m_state));
        check({tag, ".dir"}, 32'(dir), 32'(m_dir));
        check({tag, ".end_pulse"}, 32'(end_pulse), 32'(m_pulse));
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, check.
    task automatic step(input logic a_v, input logic mode_v, input string tag);
        A    = a_v;
        mode = mode_v;
        @(posedge clk);
        model_edge(a_v, mode_v);
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, clocks once
    // with A high while in reset, then releases at a falling edge.
    task automatic pulse_reset(input string tag);
        A = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        check_outputs({tag, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        // Power-on reset.
        @(negedge clk);
        pulse_reset("por");

        // Wrap mode, eight enabled advances.
        for (int i = 0; i < 8 * D; i++) step(1'b1, 1'b0, $sformatf("wrap%0d", i));
        check("wrap.end", 32'(state), 32'd0);

        // Ping-pong from reset, eight advances.
        @(negedge clk);
        pulse_reset("rst_pp");
        for (int i = 0; i < 8 * D; i++) step(1'b1, 1'b1, $sformatf("pp%0d", i));
        check("pp.end", 32'(state), 32'd2);

        // Dwell: 2 high, 5 low, 1 high, then 3 high.
        @(negedge clk);
        pulse_reset("rst_dw");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, $sformatf("dw_hi%0d", i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, $sformatf("dw_lo%0d", i));
        step(1'b1, 1'b0, "dw_resume");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $sformatf("dw_more%0d", i));

        // Mode switch: ping-pong until state 2 going down, then wrap.
        @(negedge clk);
        pulse_reset("rst_ms");
        guard = 0;
        while (!(m_state == 2 && m_dir == 0 && m_cnt == 0) && guard < 40) begin
            step(1'b1, 1'b1, $sformatf("ms_pp%0d", guard));
            guard++;
        end
        check("ms.reached", 32'(guard < 40), 32'd1);
        for (int i = 0; i < 2 * D; i++) step(1'b1, 1'b0, $sformatf("ms_wrap%0d", i));
        check("ms.final_state", 32'(state), 32'd0);
        check("ms.final_pulse", 32'(end_pulse), 32'd1);

        // Reset mid-run at state 3 in ping-pong, then resume.
        @(negedge clk);
        pulse_reset("rst_mr");
        for (int i = 0; i < 3 * D; i++) step(1'b1, 1'b1, $sformatf("mr_pre%0d", i));
        pulse_reset("mr_reset");
        for (int i = 0; i < 4 * D; i++) step(1'b1, 1'b1, $sformatf("mr_post%0d", i));

        // Randomised run with occasional mode flips, idle cycles and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                pulse_reset($sformatf("rnd_rst%0d", i));
            end else begin
                if ($urandom_range(0, 99) < 8) mode = ~mode;
                step(logic'($urandom_range(0, 99) < 75), mode, $sformatf("rnd%0d", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
